// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle shared between the timing generator and the pixel pattern blocks.
interface vga_timing_gen_if;
    logic [10:0] hc;
    logic [10:0] vc;
    logic        vidon;
    logic        hsync;
    logic        vsync;
    logic        pix_tick;
    logic        frame_start;

    modport master (
        output hc, vc, vidon, hsync, vsync, pix_tick, frame_start
    );

    modport slave (
        input hc, vc, vidon, hsync, vsync, pix_tick, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel clock-enable divider, hc/vc counters and registered
// vidon/hsync/vsync decode, all aligned to the same pixel.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic             clk,
    input  logic             clr_n,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS_C  = 11'(H_VIS);
    localparam logic [10:0] V_VIS_C  = 11'(V_VIS);
    localparam logic [10:0] HS_FIRST = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_VIS + V_FP);
    localparam logic [10:0] VS_LAST  = 11'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic SYNC_ACT  = (SYNC_POL != 0);
    localparam logic SYNC_IDLE = ~SYNC_ACT;

    logic [DIV_W-1:0] div_q, div_d;
    logic [10:0]      hc_q, hc_d;
    logic [10:0]      vc_q, vc_d;
    logic             vidon_q, vidon_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             pix_tick_q, pix_tick_d;
    logic             frame_start_q, frame_start_d;
    logic             adv;

    always_comb begin
        adv   = (div_q == DIV_LAST);
        div_d = adv ? '0 : div_q + 1'b1;
        hc_d  = hc_q;
        vc_d  = vc_q;
        if (adv) begin
            if (hc_q == H_LAST) begin
                hc_d = '0;
                vc_d = (vc_q == V_LAST) ? '0 : vc_q + 11'd1;
            end else begin
                hc_d = hc_q + 11'd1;
            end
        end
        // Decode from the next counts so the flags land in the same cycle as hc/vc.
        vidon_d       = (hc_d < H_VIS_C) && (vc_d < V_VIS_C);
        hsync_d       = ((hc_d >= HS_FIRST) && (hc_d <= HS_LAST)) ? SYNC_ACT : SYNC_IDLE;
        vsync_d       = ((vc_d >= VS_FIRST) && (vc_d <= VS_LAST)) ? SYNC_ACT : SYNC_IDLE;
        pix_tick_d    = adv;
        frame_start_d = adv && (hc_d == '0) && (vc_d == '0);
    end

    // Reset parks on the last back-porch pixel so the first advance wraps to (0,0).
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            div_q         <= '0;
            hc_q          <= H_LAST;
            vc_q          <= V_LAST;
            vidon_q       <= 1'b0;
            hsync_q       <= SYNC_IDLE;
            vsync_q       <= SYNC_IDLE;
            pix_tick_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            vidon_q       <= vidon_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            pix_tick_q    <= pix_tick_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.hc          = hc_q;
    assign vga.vc          = vc_q;
    assign vga.vidon       = vidon_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.pix_tick    = pix_tick_q;
    assign vga.frame_start = frame_start_q;
endmodule
